// File: rtl/flex_counter_pkg.sv
// Shared constants and per-edge action decode for the flexible rollover counter.

package flex_counter_pkg;

    localparam int unsigned DEF_NUM_CNT_BITS  = 4;
    localparam int unsigned DEF_ROLL_CNT_BITS = 8;

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_CLEAR,
        ACT_COUNT,
        ACT_HOLD
    } act_e;

    function automatic act_e decode_action(input logic rst, input logic clear,
                                           input logic count_enable);
        if (rst) begin
            return ACT_RESET;
        end else if (clear) begin
            return ACT_CLEAR;
        end else if (count_enable) begin
            return ACT_COUNT;
        end
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/flex_counter_sync_if.sv
// Control/status bundle of flex_counter_sync; roll_count exists only with
// FLEX_COUNTER_ROLL_CNT_EN defined.

interface flex_counter_sync_if
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
    parameter int unsigned ROLL_CNT_BITS = DEF_ROLL_CNT_BITS
);

    logic                    clear;
    logic                    count_enable;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;

`ifdef FLEX_COUNTER_ROLL_CNT_EN
    logic [ROLL_CNT_BITS-1:0] roll_count;

    modport master (
        output clear, count_enable, rollover_val,
        input  count_out, rollover_flag, roll_count
    );

    modport slave (
        input  clear, count_enable, rollover_val,
        output count_out, rollover_flag, roll_count
    );
`else
    modport master (
        output clear, count_enable, rollover_val,
        input  count_out, rollover_flag
    );

    modport slave (
        input  clear, count_enable, rollover_val,
        output count_out, rollover_flag
    );
`endif

    if (ROLL_CNT_BITS < 1) begin : g_bad_roll_bits
        $error("flex_counter_sync_if: ROLL_CNT_BITS must be at least 1");
    end

endinterface

// File: rtl/flex_counter_next.sv
// Combinational next-state logic: next count, next flag and the rollover event.

module flex_counter_next
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] count,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output act_e                    action,
    output logic [NUM_CNT_BITS-1:0] next_count,
    output logic                    next_flag,
    output logic                    roll_event
);

    logic at_roll;

    assign at_roll = (count == rollover_val);

    always_comb begin
        action     = decode_action(rst, clear, count_enable);
        next_count = count;
        next_flag  = 1'b0;
        roll_event = 1'b0;

        unique case (action)
            ACT_RESET, ACT_CLEAR: begin
                next_count = '0;
            end
            ACT_COUNT: begin
                // Restart at 1 so a period spans exactly 1..rollover_val.
                if (at_roll) begin
                    next_count = NUM_CNT_BITS'(1);
                    roll_event = 1'b1;
                end else begin
                    next_count = count + NUM_CNT_BITS'(1);
                end
            end
            ACT_HOLD: begin
                next_count = count;
            end
            default: begin
                next_count = count;
            end
        endcase

        if (action == ACT_COUNT || action == ACT_HOLD) begin
            next_flag = (next_count == rollover_val);
        end
    end

endmodule

// File: rtl/flex_counter_sync.sv
// Up-counter with runtime rollover value and registered rollover flag.
// Optional roll_count output enabled by FLEX_COUNTER_ROLL_CNT_EN.

module flex_counter_sync
    import flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS  = DEF_NUM_CNT_BITS,
    parameter int unsigned ROLL_CNT_BITS = DEF_ROLL_CNT_BITS
) (
    input logic               clk,
    input logic               rst,
    flex_counter_sync_if.slave bus
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;
    logic                    roll_event;
    act_e                    action;

    flex_counter_next #(
        .NUM_CNT_BITS (NUM_CNT_BITS)
    ) u_next (
        .rst          (rst),
        .clear        (bus.clear),
        .count_enable (bus.count_enable),
        .count        (count_q),
        .rollover_val (bus.rollover_val),
        .action       (action),
        .next_count   (count_d),
        .next_flag    (flag_d),
        .roll_event   (roll_event)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.count_out     = count_q;
    assign bus.rollover_flag = flag_q;

`ifdef FLEX_COUNTER_ROLL_CNT_EN
    logic [ROLL_CNT_BITS-1:0] roll_count_q;

    always_ff @(posedge clk) begin
        if (rst || action == ACT_CLEAR) begin
            roll_count_q <= '0;
        end else if (roll_event) begin
            roll_count_q <= roll_count_q + ROLL_CNT_BITS'(1);
        end
    end

    assign bus.roll_count = roll_count_q;
`else
    logic unused_roll;
    assign unused_roll = roll_event ^ (action == ACT_CLEAR);
`endif

    if (NUM_CNT_BITS < 2 || NUM_CNT_BITS > 32) begin : g_bad_cnt_bits
        $error("flex_counter_sync: NUM_CNT_BITS must be in 2..32");
    end
    if (ROLL_CNT_BITS < 1) begin : g_bad_roll_bits
        $error("flex_counter_sync: ROLL_CNT_BITS must be at least 1");
    end

endmodule

// File: tb/tb_flex_counter_sync.sv
// Directed bench for flex_counter_sync with hand-computed expectations.

module tb_flex_counter_sync;

    localparam int unsigned NB = 4;
    localparam int unsigned RB = 8;

    logic tb_clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 tb_clk = ~tb_clk;

    flex_counter_sync_if #(
        .NUM_CNT_BITS  (NB),
        .ROLL_CNT_BITS (RB)
    ) bus ();

    flex_counter_sync #(
        .NUM_CNT_BITS  (NB),
        .ROLL_CNT_BITS (RB)
    ) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cf(input string tag, input int cnt, input logic flag);
        check({tag, ".count"}, 32'(bus.count_out), 32'(cnt));
        check({tag, ".flag"}, 32'(bus.rollover_flag), 32'(flag));
    endtask

    // Advance n rising edges, then sit on the falling edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge tb_clk);
        @(negedge tb_clk);
    endtask

    initial begin
        rst              = 1'b1;
        bus.clear        = 1'b0;
        bus.count_enable = 1'b0;
        bus.rollover_val = 4'd15;
        @(negedge tb_clk);

        step(2);
        check_cf("reset", 0, 1'b0);
`ifdef FLEX_COUNTER_ROLL_CNT_EN
        check("reset.roll", 32'(bus.roll_count), 32'd0);
`endif

        rst = 1'b0;
        step(1);
        check_cf("hold_after_reset", 0, 1'b0);

        bus.count_enable = 1'b1;
        step(2);
        check_cf("count2", 2, 1'b0);
        step(13);
        check_cf("reach15", 15, 1'b1);
        step(1);
        check_cf("roll_to1", 1, 1'b0);

        step(1);
        check_cf("at2", 2, 1'b0);
        bus.rollover_val = 4'd4;
        step(1);
        check_cf("rv4_e1", 3, 1'b0);
        step(1);
        check_cf("rv4_e2", 4, 1'b1);
        step(1);
        check_cf("rv4_e3", 1, 1'b0);

        bus.clear = 1'b1;
        step(1);
        check_cf("clear_over_en", 0, 1'b0);
        bus.clear = 1'b0;
        step(1);
        check_cf("resume", 1, 1'b0);

        step(3);
        check_cf("at4", 4, 1'b1);
        bus.count_enable = 1'b0;
        step(3);
        check_cf("hold4", 4, 1'b1);
        bus.rollover_val = 4'd9;
        step(1);
        check_cf("rv_change_drop", 4, 1'b0);

        // Lower rollover below count: wraps through 0 before meeting it.
        bus.rollover_val = 4'd2;
        bus.count_enable = 1'b1;
        step(1);
        check_cf("lower_e1", 5, 1'b0);
        step(10);
        check_cf("lower_15", 15, 1'b0);
        step(1);
        check_cf("lower_wrap0", 0, 1'b0);
        step(2);
        check_cf("lower_meet2", 2, 1'b1);

        // rollover_val = 0 is reached only via the 2^N wrap.
        bus.rollover_val = 4'd0;
        bus.clear        = 1'b1;
        step(1);
        check_cf("rv0_clear", 0, 1'b0);
        bus.clear = 1'b0;
        step(15);
        check_cf("rv0_15", 15, 1'b0);
        step(1);
        check_cf("rv0_wrap", 0, 1'b1);
        step(1);
        check_cf("rv0_next", 1, 1'b0);

        bus.rollover_val = 4'd1;
        bus.clear        = 1'b1;
        step(1);
        bus.clear = 1'b0;
        step(1);
        check_cf("rv1_first", 1, 1'b1);
        step(1);
        check_cf("rv1_second", 1, 1'b1);

        // Reset overrides clear and enable mid-count.
        bus.rollover_val = 4'd9;
        step(2);
        rst       = 1'b1;
        bus.clear = 1'b1;
        step(1);
        check_cf("reset_mid", 0, 1'b0);
        rst       = 1'b0;
        bus.clear = 1'b0;

        bus.rollover_val = 4'd3;
        bus.clear        = 1'b1;
        step(1);
        bus.clear = 1'b0;
        step(9);
        check_cf("rv3_9edges", 3, 1'b1);
`ifdef FLEX_COUNTER_ROLL_CNT_EN
        check("rv3.roll", 32'(bus.roll_count), 32'd2);
        step(1);
        check("rv3.roll_inc", 32'(bus.roll_count), 32'd3);
        bus.clear = 1'b1;
        step(1);
        check("clear.roll", 32'(bus.roll_count), 32'd0);
        bus.clear = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
